// File: rtl/cnn_pkg.sv
// cnn_pkg: constants and types shared by the feature-map read and write address paths
package cnn_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_PLANE_SIZE = 196;
  localparam int DEF_NUM_PLANES = 4;
  localparam int DEF_PLANE_STRIDE = 196;
  localparam int DEF_RD_LAT = 2;
  localparam int SB_W = 10;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} fmap_state_e;
  typedef struct packed {
    logic last_pix;
    logic last_plane;
    logic [7:0] plane_idx;
  } fmap_sb_t;
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction
endpackage

// File: rtl/fmap_rd_fifo.sv
// fmap_rd_fifo: first-word fall-through FIFO with occupancy count for read-return data
module fmap_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 26,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic pop;
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    pop = rd_en && (count_q != '0);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = wr_data;
    wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d = count_q + CW'(wr_en) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  assign rd_data = mem_q[rd_ptr_q];
  assign rd_valid = count_q != '0;
  assign count = count_q;
  // credit control upstream guarantees a free slot for every returning read
  assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && count_q == CW'(DEPTH)));
endmodule

// File: rtl/fmap_plane_reader.sv
// fmap_plane_reader: fetches NUM_PLANES feature-map planes from result memory and streams
// them out over valid/ready, using a credit-limited prefetch FIFO to hide read latency.
module fmap_plane_reader
  import cnn_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PLANE_SIZE = DEF_PLANE_SIZE,
  parameter int NUM_PLANES = DEF_NUM_PLANES,
  parameter int PLANE_STRIDE = DEF_PLANE_STRIDE,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last_pix,
  output logic              out_last_plane,
  output logic [7:0]        out_plane_idx
);
  localparam int FIFO_DEPTH = fifo_depth(RD_LAT);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PIX_W = $clog2(PLANE_SIZE + 1);
  localparam int FW = DATA_W + SB_W;
  fmap_state_e state_q, state_d;
  logic [ADDR_W-1:0] plane_base_q, plane_base_d, cur_addr_q, cur_addr_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [7:0] plane_q, plane_d;
  logic done_q, done_d;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  fmap_sb_t pipe_sb_q [RD_LAT];
  fmap_sb_t pipe_sb_d [RD_LAT];
  logic [CW-1:0] fifo_count;
  logic [FW-1:0] fifo_rd_data;
  fmap_sb_t head_sb;
  logic pop, issue, credit, at_last_pix, at_last_plane;
  always_comb begin
    pop = out_valid && out_ready;
    at_last_pix = pix_q == PIX_W'(PLANE_SIZE - 1);
    at_last_plane = plane_q == 8'(NUM_PLANES - 1);
    // a beat leaving this cycle already frees its slot
    credit = (int'(fifo_count) - int'(pop) + $countones(pipe_vld_q)) < FIFO_DEPTH;
    issue = (state_q == ST_RUN) && credit;
    pipe_vld_d[0] = issue;
    pipe_sb_d[0] = '{last_pix: at_last_pix, last_plane: at_last_plane, plane_idx: plane_q};
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_sb_d[i] = pipe_sb_q[i-1];
    end
    state_d = state_q;
    plane_base_d = plane_base_q;
    cur_addr_d = cur_addr_q;
    pix_d = pix_q;
    plane_d = plane_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        plane_base_d = base_addr;
        cur_addr_d = base_addr;
        pix_d = '0;
        plane_d = '0;
        state_d = ST_RUN;
      end
      ST_RUN: if (issue) begin
        if (at_last_pix) begin
          pix_d = '0;
          plane_d = plane_q + 8'd1;
          plane_base_d = plane_base_q + ADDR_W'(PLANE_STRIDE);
          cur_addr_d = plane_base_d;
          if (at_last_plane) state_d = ST_DRAIN;
        end else begin
          pix_d = pix_q + PIX_W'(1);
          cur_addr_d = cur_addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (done_q) state_d = ST_IDLE;
        else if (pop && out_last_pix && out_last_plane) done_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      plane_base_q <= '0;
      cur_addr_q <= '0;
      pix_q <= '0;
      plane_q <= '0;
      done_q <= 1'b0;
      pipe_vld_q <= '0;
      pipe_sb_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      plane_base_q <= plane_base_d;
      cur_addr_q <= cur_addr_d;
      pix_q <= pix_d;
      plane_q <= plane_d;
      done_q <= done_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_sb_q <= pipe_sb_d;
    end
  end
  fmap_rd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(pipe_vld_q[RD_LAT-1]),
    .wr_data({mem_rd_data, pipe_sb_q[RD_LAT-1]}),
    .rd_en(out_ready),
    .rd_data(fifo_rd_data),
    .rd_valid(out_valid),
    .count(fifo_count)
  );
  assign {out_data, head_sb} = fifo_rd_data;
  assign out_last_pix = head_sb.last_pix;
  assign out_last_plane = head_sb.last_plane;
  assign out_plane_idx = head_sb.plane_idx;
  assign busy = state_q != ST_IDLE;
  assign done = done_q;
  assign mem_rd_en = issue;
  assign mem_rd_addr = cur_addr_q;
endmodule
